// File: rtl/lfsr_press_gen.sv
// Computer-press generator: compares the LFSR sample against the switch level and
// emits rate-limited single-cycle press pulses, counting them with saturation.
module lfsr_press_gen #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned HOLDOFF = 3,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             game_over,
    input  logic [WIDTH-1:0] rand_val,
    input  logic [WIDTH-1:0] level,
    output logic             press,
    output logic             busy,
    output logic [CNT_W-1:0] press_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_PRESS,
        S_COOLDOWN
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

    state_t           state_q, state_d;
    logic [7:0]       cool_q, cool_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             go_q;
    logic             press_q, press_d;
    logic             busy_q, busy_d;
    logic             stopped;

    always_comb begin
        stopped = game_over | go_q;
        state_d = state_q;
        cool_d  = cool_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (enable && !stopped) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!enable || stopped) begin
                    state_d = S_IDLE;
                end else if (rand_val < level) begin
                    state_d = S_PRESS;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
            end
            S_PRESS: begin
                // A registered press always completes; aborts are honoured from COOLDOWN.
                state_d = S_COOLDOWN;
                cool_d  = HOLD_LOAD;
            end
            S_COOLDOWN: begin
                if (!enable || stopped) begin
                    state_d = S_IDLE;
                    cool_d  = '0;
                end else if (cool_q == '0) begin
                    state_d = S_ARMED;
                end else begin
                    cool_d = cool_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        press_d = (state_d == S_PRESS);
        busy_d  = (state_d == S_PRESS) || (state_d == S_COOLDOWN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cool_q  <= '0;
            cnt_q   <= '0;
            go_q    <= 1'b0;
            press_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cool_q  <= cool_d;
            cnt_q   <= cnt_d;
            go_q    <= go_q | game_over;
            press_q <= press_d;
            busy_q  <= busy_d;
        end
    end

    assign press       = press_q;
    assign busy        = busy_q;
    assign press_count = cnt_q;

endmodule

// File: tb/tb_lfsr_press_gen.sv
// Scoreboard bench for lfsr_press_gen: stimulus queues expected press events
// (cycle, count); a monitor pops and checks them whenever press is seen.
module tb_lfsr_press_gen;

    logic       clk = 1'b0;
    logic       reset, enable, game_over;
    logic [7:0] rand_val, level;
    logic       press, busy;
    logic [3:0] press_count;

    lfsr_press_gen #(.WIDTH(8), .HOLDOFF(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .game_over(game_over),
        .rand_val(rand_val), .level(level),
        .press(press), .busy(busy), .press_count(press_count)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int cnt; } exp_t;
    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc++;

    task automatic check(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic push(int c, int n);
        exp_t e;
        e.cyc = c;
        e.cnt = n;
        exp_q.push_back(e);
    endtask

    // Monitor: every press must match the head of the queue; stale heads are misses.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("missed_press_cycle", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (press) begin
            if (exp_q.size() == 0) begin
                check("unexpected_press", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("press_cycle", cyc, e.cyc);
                check("press_count", int'(press_count), e.cnt);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int t0;
        reset = 1'b1; enable = 1'b0; game_over = 1'b0; rand_val = '0; level = '0;
        repeat (3) @(negedge clk);
        check("reset_press", int'(press), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_count", int'(press_count), 0);
        reset = 1'b0;

        // level = 0: never presses over a full rand_val sweep
        @(negedge clk);
        level = 8'h00; enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rand_val = 8'(i);
            @(negedge clk);
        end
        check("lvl0_count", int'(press_count), 0);
        enable = 1'b0;

        // level = FF: period-5 presses, busy only in PRESS/COOLDOWN
        do_reset();
        level = 8'hFF; rand_val = 8'h5A; enable = 1'b1;
        t0 = cyc;
        push(t0 + 2, 1); push(t0 + 7, 2); push(t0 + 12, 3);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            check("busy_pattern", int'(busy), (c >= 2 && ((c - 2) % 5) < 4) ? 1 : 0);
        end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("disable_busy", int'(busy), 0);
        check("disable_count_held", int'(press_count), 3);

        // strict less-than: only 3F presses against level 40
        do_reset();
        level = 8'h40; rand_val = 8'h40; enable = 1'b1;
        t0 = cyc;
        push(t0 + 5, 1); push(t0 + 11, 2);
        repeat (4) @(negedge clk);
        rand_val = 8'h3F;
        @(negedge clk);
        rand_val = 8'h40;
        repeat (5) @(negedge clk);
        rand_val = 8'h3F;
        @(negedge clk);
        rand_val = 8'h40;
        repeat (9) @(negedge clk);
        check("strict_lt_count", int'(press_count), 2);

        // saturation at 4'hF with pulses continuing
        do_reset();
        level = 8'hFF; rand_val = 8'h5A; enable = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 20; k++) push(t0 + 2 + 5 * k, (k + 1 > 15) ? 15 : k + 1);
        repeat (100) @(negedge clk);
        check("sat_count", int'(press_count), 15);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // game_over pulse in COOLDOWN is sticky until reset
        do_reset();
        level = 8'hFF; rand_val = 8'h5A; enable = 1'b1;
        t0 = cyc;
        push(t0 + 2, 1);
        repeat (3) @(negedge clk);
        check("gameover_in_cooldown", int'(busy), 1);
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
        check("gameover_idle_busy", int'(busy), 0);
        repeat (20) @(negedge clk);
        check("gameover_busy", int'(busy), 0);
        check("gameover_count_held", int'(press_count), 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_after_go_count", int'(press_count), 0);
        check("rst_after_go_busy", int'(busy), 0);
        @(negedge clk);
        t0 = cyc;
        push(t0 + 2, 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // enable drops in the cycle ARMED would press
        do_reset();
        level = 8'h40; rand_val = 8'h40; enable = 1'b1;
        repeat (2) @(negedge clk);
        rand_val = 8'h3F; enable = 1'b0;
        @(negedge clk);
        check("en_drop_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        check("en_drop_count", int'(press_count), 0);

        // reset in the middle of PRESS
        level = 8'hFF; rand_val = 8'h5A; enable = 1'b1;
        t0 = cyc;
        push(t0 + 2, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_press", int'(press), 0);
        check("rst_mid_count", int'(press_count), 0);
        reset = 1'b0; enable = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
